// File: rtl/int_pkg.sv
// Shared interrupt definitions: FSM state type, cause-code width and default vector layout.
// Reused by the interrupt front-end, CP0 and exception logic.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  localparam int          CAUSE_W        = 5;
  localparam int          CAUSE_BASE_DEF = 13;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h8000_0180;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  // Cause code of a source; wraps modulo 2^CAUSE_W.
  function automatic logic [CAUSE_W-1:0] cause_code(input int base, input int idx);
    return CAUSE_W'(base + idx);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over NUM_SRC request bits.
module int_prio_enc #(
  parameter int NUM_SRC = 2,
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      o_idx = i_req[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/interrupt_vector_unit.sv
// Stateful N-channel interrupt front-end: pending latch, masked fixed priority, registered vector/cause.
// Build option INT_EDGE_DETECT_EN: defined = edge-latched pending, undefined = level-following pending.
module interrupt_vector_unit
  import int_pkg::*;
#(
  parameter int                    NUM_SRC    = 2,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CAUSE_BASE = CAUSE_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] VEC_BASE   = DATA_WIDTH'(VEC_BASE_DEF),
  parameter logic [DATA_WIDTH-1:0] VEC_STRIDE = DATA_WIDTH'(VEC_STRIDE_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_SRC-1:0]    i_int_src,
  input  logic [NUM_SRC-1:0]    i_int_mask,
  input  logic                  i_irq_ack,
  input  logic                  i_eret,
  output logic                  o_irq_req,
  output logic [DATA_WIDTH-1:0] o_vector_out,
  output logic [CAUSE_W-1:0]    o_cause_out,
  output logic                  o_in_service,
  output logic [NUM_SRC-1:0]    o_pending
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  int_state_e              r_state;
  logic [NUM_SRC-1:0]      r_pending;
  logic                    r_irq_req;
  logic                    r_in_service;
  logic [DATA_WIDTH-1:0]   r_vector;
  logic [CAUSE_W-1:0]      r_cause;
  logic [NUM_SRC-1:0]      w_pending_nxt;
  logic                    w_valid;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_vec;
  logic [CAUSE_W-1:0]      w_cause;

  int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .i_req   (r_pending & i_int_mask),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_vec   = VEC_BASE + DATA_WIDTH'(w_idx) * VEC_STRIDE;
  assign w_cause = cause_code(CAUSE_BASE, int'(w_idx));

`ifdef INT_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] r_src_d;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;

  // Previous-cycle line sample; tracks the line through reset so a held line is not seen as a new edge.
  always_ff @(posedge i_clk) begin
    r_src_d <= i_int_src;
  end

  // Rising edges set, ack of the serviced source clears; set wins on collision.
  always_comb begin
    w_set         = i_int_src & ~r_src_d;
    w_clr         = (r_state == ST_REQ && i_irq_ack) ? (NUM_SRC'(1) << r_idx) : '0;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  // Index of the committed source, needed to clear its pending bit on ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_idx <= w_idx;
    end else begin
      r_idx <= r_idx;
    end
  end
`else
  // Level mode: pending simply mirrors the lines one cycle late.
  always_comb begin
    w_pending_nxt = i_int_src;
  end
`endif

  // Pending register, latched regardless of mask.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Request/service FSM; vector and cause are captured once and frozen until the next commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_irq_req    <= 1'b0;
      r_in_service <= 1'b0;
      r_vector     <= '0;
      r_cause      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_vector  <= w_vec;
            r_cause   <= w_cause;
            r_irq_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_irq_ack) begin
            r_irq_req    <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (i_eret) begin
            r_in_service <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_irq_req    <= 1'b0;
          r_in_service <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_irq_req    = r_irq_req;
  assign o_in_service = r_in_service;
  assign o_vector_out = r_vector;
  assign o_cause_out  = r_cause;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_interrupt_vector_unit.sv
// Self-checking bench for interrupt_vector_unit; reference model selects edge or level behaviour from INT_EDGE_DETECT_EN.
module tb_interrupt_vector_unit;

  localparam logic [31:0] VB = 32'h8000_0180;
  localparam logic [31:0] VS = 32'h0000_0020;
`ifdef INT_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  int_src, int_mask;
  logic        irq_ack, eret;
  logic        irq_req, in_service;
  logic [31:0] vector_out;
  logic [4:0]  cause_out;
  logic [1:0]  pending;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1 = request outstanding, 2 = handler active.
  int          m_phase;
  int          m_k;
  logic [1:0]  m_pend, m_prev;
  logic [31:0] m_vec;
  logic [4:0]  m_cause;

  interrupt_vector_unit dut (
    .i_clk(clk), .i_rst(rst), .i_int_src(int_src), .i_int_mask(int_mask),
    .i_irq_ack(irq_ack), .i_eret(eret), .o_irq_req(irq_req), .o_vector_out(vector_out),
    .o_cause_out(cause_out), .o_in_service(in_service), .o_pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [1:0] v);
    for (int i = 0; i < 2; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int k;
    logic [1:0] clr;
    clr = 2'b00;
    if (rst) begin
      m_phase = 0; m_pend = 2'b00; m_vec = 32'd0; m_cause = 5'd0; m_k = 0;
    end else begin
      k = lowest(m_pend & int_mask);
      if (m_phase == 0 && k >= 0) begin
        m_phase = 1; m_k = k;
        m_vec = VB + 32'(k) * VS;
        m_cause = 5'((13 + k) % 32);
      end else if (m_phase == 1 && irq_ack) begin
        m_phase = 2; clr = 2'(1 << m_k);
      end else if (m_phase == 2 && eret) begin
        m_phase = 0;
      end
      if (EDGE) m_pend = (m_pend & ~clr) | (int_src & ~m_prev);
      else m_pend = int_src;
    end
    m_prev = int_src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; int_src = 2'b00; int_mask = 2'b11; irq_ack = 1'b0; eret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; int_src = 2'b00; int_mask = 2'b00; irq_ack = 1'b0; eret = 1'b0;
    m_prev = 2'b00;
    tick(); tick();
    rst = 1'b0;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq_req); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL reset_insvc: got %b want 0", in_service); end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL reset_pending: got %b want 00", pending); end
    checks++; if (vector_out !== 32'd0) begin failures++; $display("FAIL reset_vector: got %h want 0", vector_out); end
    checks++; if (cause_out !== 5'd0) begin failures++; $display("FAIL reset_cause: got %0d want 0", cause_out); end
  endtask

  task automatic test_single();
    idle_inputs(); int_src = 2'b01;
    tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL single_early: got %b want 0", irq_req); end
    checks++; if (pending !== 2'b01) begin failures++; $display("FAIL single_pend: got %b want 01", pending); end
    tick();
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL single_irq: got %b want 1", irq_req); end
    checks++; if (vector_out !== 32'h8000_0180) begin failures++; $display("FAIL single_vec: got %h want 80000180", vector_out); end
    checks++; if (cause_out !== 5'd13) begin failures++; $display("FAIL single_cause: got %0d want 13", cause_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0 || in_service !== 1'b1) begin failures++; $display("FAIL single_ack: got irq=%b insvc=%b want 0/1", irq_req, in_service); end
    checks++; if (pending !== m_pend) begin failures++; $display("FAIL single_ack_pend: got %b want %b", pending, m_pend); end
    int_src = 2'b00; eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL single_eret: got %b want 0", in_service); end
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL single_quiet: got %b want 0", irq_req); end
  endtask

  task automatic test_simultaneous();
    idle_inputs(); int_src = 2'b11;
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || cause_out !== 5'd13) begin failures++; $display("FAIL simul_first: got irq=%b cause=%0d want 1/13", irq_req, cause_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b10; eret = 1'b1; tick(); eret = 1'b0;
    tick();
    checks++; if (irq_req !== 1'b1 || cause_out !== 5'd14) begin failures++; $display("FAIL simul_second: got irq=%b cause=%0d want 1/14", irq_req, cause_out); end
    checks++; if (vector_out !== 32'h8000_01A0) begin failures++; $display("FAIL simul_vec: got %h want 800001a0", vector_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b00; eret = 1'b1; tick(); eret = 1'b0;
    tick();
  endtask

  task automatic test_masking();
    idle_inputs(); int_mask = 2'b01; int_src = 2'b10;
    tick(); tick(); tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL mask_irq: got %b want 0", irq_req); end
    checks++; if (pending !== 2'b10) begin failures++; $display("FAIL mask_pend: got %b want 10", pending); end
    int_mask = 2'b11;
    tick();
    checks++; if (irq_req !== 1'b1 || cause_out !== 5'd14) begin failures++; $display("FAIL mask_unmask: got irq=%b cause=%0d want 1/14", irq_req, cause_out); end
    int_mask = 2'b00; tick();
    checks++; if (irq_req !== 1'b1 || cause_out !== 5'd14) begin failures++; $display("FAIL mask_frozen: got irq=%b cause=%0d want 1/14", irq_req, cause_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b00; eret = 1'b1; tick(); eret = 1'b0;
    tick();
  endtask

  task automatic test_service_blocking();
    idle_inputs(); int_src = 2'b10;
    tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b11;
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL block_irq: got %b want 0", irq_req); end
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL block_pend0: got %b want 1", pending[0]); end
    int_src = 2'b01; eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (in_service !== 1'b0 || irq_req !== 1'b0) begin failures++; $display("FAIL block_eret: got insvc=%b irq=%b want 0/0", in_service, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || cause_out !== 5'd13) begin failures++; $display("FAIL block_next: got irq=%b cause=%0d want 1/13", irq_req, cause_out); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b00; eret = 1'b1; tick(); eret = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs(); int_src = 2'b01;
    tick(); tick();
    rst = 1'b1; int_src = 2'b00; tick(); rst = 1'b0;
    checks++; if (irq_req !== 1'b0 || pending !== 2'b00 || in_service !== 1'b0) begin failures++; $display("FAIL midrst: got irq=%b pend=%b insvc=%b want 0/00/0", irq_req, pending, in_service); end
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL midrst_quiet: got %b want 0", irq_req); end
    eret = 1'b1; tick(); eret = 1'b0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin failures++; $display("FAIL spurious: got irq=%b insvc=%b want 0/0", irq_req, in_service); end
  endtask

  task automatic test_rerequest();
    logic exp_re;
    exp_re = EDGE ? 1'b0 : 1'b1;
    idle_inputs(); int_src = 2'b10;
    tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    checks++; if (irq_req !== exp_re) begin failures++; $display("FAIL rereq: got %b want %b", irq_req, exp_re); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_src = 2'b00; eret = 1'b1; tick(); eret = 1'b0;
    tick(); tick();
    checks++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin failures++; $display("FAIL rereq_drop: got irq=%b insvc=%b want 0/0", irq_req, in_service); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      int_src  = 2'($urandom_range(0, 3));
      int_mask = 2'($urandom_range(0, 3));
      irq_ack  = ($urandom_range(0, 2) == 0);
      eret     = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (irq_req !== (m_phase == 1)) begin failures++; $display("FAIL rnd_irq c=%0d: got %b want %b", c, irq_req, (m_phase == 1)); end
      checks++; if (in_service !== (m_phase == 2)) begin failures++; $display("FAIL rnd_insvc c=%0d: got %b want %b", c, in_service, (m_phase == 2)); end
      checks++; if (pending !== m_pend) begin failures++; $display("FAIL rnd_pend c=%0d: got %b want %b", c, pending, m_pend); end
      checks++; if (vector_out !== m_vec) begin failures++; $display("FAIL rnd_vec c=%0d: got %h want %h", c, vector_out, m_vec); end
      checks++; if (cause_out !== m_cause) begin failures++; $display("FAIL rnd_cause c=%0d: got %0d want %0d", c, cause_out, m_cause); end
    end
  endtask

  initial begin
    m_phase = 0; m_k = 0; m_pend = 2'b00; m_prev = 2'b00; m_vec = 32'd0; m_cause = 5'd0;
    test_reset();
    test_single();
    test_simultaneous();
    test_masking();
    test_service_blocking();
    test_reset_mid();
    test_rerequest();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
